axi_slave_mem: RTL and testbench



---
 rtl/axi_slave_mem.sv | 250 +++++++++++++++++++++++++
 tb/tb_axi_slave_mem.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/axi_slave_mem.sv
// AXI4 slave with internal word-addressed memory; independent write and read burst engines.
// Optional pseudo-random WREADY/R-beat throttling: define AXI_SLAVE_MEM_BACKPRESSURE_EN.
module axi_slave_mem #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MEM_DEPTH = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
    parameter int unsigned READY_DELAY = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDR_WIDTH-1:0]   AWADDR,
    input  logic [7:0]              AWLEN,
    input  logic [2:0]              AWSIZE,
    input  logic [1:0]              AWBURST,
    input  logic                    AWVALID,
    output logic                    AWREADY,
    input  logic [DATA_WIDTH-1:0]   WDATA,
    input  logic [DATA_WIDTH/8-1:0] WSTRB,
    input  logic                    WLAST,
    input  logic                    WVALID,
    output logic                    WREADY,
    output logic [1:0]              BRESP,
    output logic                    BVALID,
    input  logic                    BREADY,
    input  logic [ADDR_WIDTH-1:0]   ARADDR,
    input  logic [7:0]              ARLEN,
    input  logic [2:0]              ARSIZE,
    input  logic [1:0]              ARBURST,
    input  logic                    ARVALID,
    output logic                    ARREADY,
    output logic [DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]              RRESP,
    output logic                    RLAST,
    output logic                    RVALID,
    input  logic                    RREADY
);
    localparam int unsigned NB   = DATA_WIDTH / 8;
    localparam int unsigned LSB  = $clog2(NB);
    localparam int unsigned IDXW = $clog2(MEM_DEPTH);
    localparam logic [3:0]  RDLY = 4'(READY_DELAY);
    localparam logic [1:0]  OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
    typedef enum logic {R_IDLE, R_DATA} rstate_e;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return ((a - BASE_ADDR) >> LSB) < ADDR_WIDTH'(MEM_DEPTH);
    endfunction

    function automatic logic [IDXW-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
        return IDXW'((a - BASE_ADDR) >> LSB);
    endfunction

    // Burst attributes that make every beat SLVERR regardless of address.
    function automatic logic static_err(input logic [ADDR_WIDTH-1:0] a, input logic [7:0] len,
                                        input logic [2:0] size, input logic [1:0] burst);
        logic [ADDR_WIDTH-1:0] szmask;
        szmask = (ADDR_WIDTH'(1) << size) - ADDR_WIDTH'(1);
        return (size > 3'(LSB)) || (burst == 2'b11) ||
               (burst == 2'b10 && !(len inside {8'd1, 8'd3, 8'd7, 8'd15})) ||
               (burst == 2'b10 && (a & szmask) != '0);
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a, input logic [7:0] len,
                                                        input logic [2:0] size, input logic [1:0] burst);
        logic [ADDR_WIDTH-1:0] step, mask;
        step = ADDR_WIDTH'(1) << size;
        mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
        case (burst)
            2'b00:   return a;
            2'b10:   return (a & ~mask) | ((a + step) & mask);
            default: return a + step;
        endcase
    endfunction

    function automatic logic [1:0] beat_resp(input logic [ADDR_WIDTH-1:0] a, input logic slv);
        return !in_range(a) ? DECERR : (slv ? SLVERR : OKAY);
    endfunction

    logic bp_w, bp_r;
`ifdef AXI_SLAVE_MEM_BACKPRESSURE_EN
    logic [15:0] lfsr_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) lfsr_q <= 16'hACE1;
        else       lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
    assign bp_w = lfsr_q[0];
    assign bp_r = lfsr_q[1];
`else
    assign bp_w = 1'b0;
    assign bp_r = 1'b0;
`endif

    // ---------------- write side ----------------
    wstate_e               wstate_q;
    logic [3:0]            awcnt_q;
    logic [ADDR_WIDTH-1:0] waddr_q;
    logic [7:0]            wlen_q, wcnt_q;
    logic [2:0]            wsize_q;
    logic [1:0]            wburst_q, bresp_q;
    logic                  wslv_q, wdec_q, wmis_q, bvalid_q;
    logic                  aw_hs, w_hs, w_last, w_dec, w_mis;

    assign AWREADY = !reset && wstate_q == W_IDLE && AWVALID && awcnt_q == RDLY;
    assign WREADY  = wstate_q == W_DATA && !bp_w;
    assign BVALID  = bvalid_q;
    assign BRESP   = bresp_q;
    assign aw_hs   = AWVALID && AWREADY;
    assign w_hs    = WVALID && WREADY;
    assign w_last  = wcnt_q == wlen_q;
    assign w_dec   = !in_range(waddr_q);
    assign w_mis   = WLAST != w_last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wstate_q <= W_IDLE;
            awcnt_q  <= '0;
            waddr_q  <= '0;
            wlen_q   <= '0;
            wcnt_q   <= '0;
            wsize_q  <= '0;
            wburst_q <= '0;
            wslv_q   <= 1'b0;
            wdec_q   <= 1'b0;
            wmis_q   <= 1'b0;
            bvalid_q <= 1'b0;
            bresp_q  <= OKAY;
        end else begin
            case (wstate_q)
                W_IDLE: begin
                    if (aw_hs) begin
                        waddr_q  <= AWADDR;
                        wlen_q   <= AWLEN;
                        wsize_q  <= AWSIZE;
                        wburst_q <= AWBURST;
                        wslv_q   <= static_err(AWADDR, AWLEN, AWSIZE, AWBURST);
                        wdec_q   <= 1'b0;
                        wmis_q   <= 1'b0;
                        wcnt_q   <= '0;
                        awcnt_q  <= '0;
                        wstate_q <= W_DATA;
                    end else begin
                        awcnt_q <= AWVALID ? awcnt_q + 4'd1 : 4'd0;
                    end
                end
                W_DATA: begin
                    if (w_hs) begin
                        waddr_q <= next_addr(waddr_q, wlen_q, wsize_q, wburst_q);
                        wcnt_q  <= wcnt_q + 8'd1;
                        wdec_q  <= wdec_q | w_dec;
                        wmis_q  <= wmis_q | w_mis;
                        // Beat count, not WLAST, closes the burst.
                        if (w_last) begin
                            wstate_q <= W_RESP;
                            bvalid_q <= 1'b1;
                            bresp_q  <= (wdec_q || w_dec) ? DECERR :
                                        (wslv_q || wmis_q || w_mis) ? SLVERR : OKAY;
                        end
                    end
                end
                default: begin
                    if (BREADY) begin
                        bvalid_q <= 1'b0;
                        wstate_q <= W_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_hs && !wslv_q && !w_dec)
            for (int b = 0; b < NB; b++)
                if (WSTRB[b]) mem[word_idx(waddr_q)][b*8 +: 8] <= WDATA[b*8 +: 8];
    end

    // ---------------- read side ----------------
    rstate_e               rstate_q;
    logic [3:0]            arcnt_q;
    logic [ADDR_WIDTH-1:0] raddr_q, cur_addr;
    logic [7:0]            rlen_q, cur_len;
    logic [8:0]            rcnt_q, cur_cnt;
    logic [2:0]            rsize_q, cur_size;
    logic [1:0]            rburst_q, cur_burst, cur_resp, rresp_q;
    logic                  rslv_q, cur_slv, rvalid_q, rlast_q, ar_hs, r_launch;
    logic [DATA_WIDTH-1:0] rdata_q;

    assign ARREADY = !reset && rstate_q == R_IDLE && ARVALID && arcnt_q == RDLY;
    assign ar_hs   = ARVALID && ARREADY;
    assign RVALID  = rvalid_q;
    assign RDATA   = rdata_q;
    assign RRESP   = rresp_q;
    assign RLAST   = rlast_q;

    // The first beat is launched straight off the AR handshake so it appears one cycle later.
    assign cur_addr  = ar_hs ? ARADDR  : raddr_q;
    assign cur_len   = ar_hs ? ARLEN   : rlen_q;
    assign cur_size  = ar_hs ? ARSIZE  : rsize_q;
    assign cur_burst = ar_hs ? ARBURST : rburst_q;
    assign cur_slv   = ar_hs ? static_err(ARADDR, ARLEN, ARSIZE, ARBURST) : rslv_q;
    assign cur_cnt   = ar_hs ? 9'd0 : rcnt_q;
    assign cur_resp  = beat_resp(cur_addr, cur_slv);
    assign r_launch  = ar_hs || (rstate_q == R_DATA && rcnt_q <= {1'b0, rlen_q} &&
                                 (!rvalid_q || RREADY) && !bp_r);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rstate_q <= R_IDLE;
            arcnt_q  <= '0;
            raddr_q  <= '0;
            rlen_q   <= '0;
            rcnt_q   <= '0;
            rsize_q  <= '0;
            rburst_q <= '0;
            rslv_q   <= 1'b0;
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
            rresp_q  <= OKAY;
            rdata_q  <= '0;
        end else begin
            if (ar_hs) begin
                rstate_q <= R_DATA;
                rlen_q   <= ARLEN;
                rsize_q  <= ARSIZE;
                rburst_q <= ARBURST;
                rslv_q   <= cur_slv;
                arcnt_q  <= '0;
            end else if (rstate_q == R_IDLE) begin
                arcnt_q <= ARVALID ? arcnt_q + 4'd1 : 4'd0;
            end
            if (r_launch) begin
                rvalid_q <= 1'b1;
                rdata_q  <= (cur_resp == OKAY) ? mem[word_idx(cur_addr)] : '0;
                rresp_q  <= cur_resp;
                rlast_q  <= cur_cnt == {1'b0, cur_len};
                raddr_q  <= next_addr(cur_addr, cur_len, cur_size, cur_burst);
                rcnt_q   <= cur_cnt + 9'd1;
            end else if (rvalid_q && RREADY) begin
                rvalid_q <= 1'b0;
                if (rlast_q) begin
                    rlast_q  <= 1'b0;
                    rstate_q <= R_IDLE;
                end
            end
        end
    end
endmodule

// File: tb/tb_axi_slave_mem.sv
// Directed bench for axi_slave_mem: single-beat vector table plus burst, wrap, fixed, error and reset sequences.
module tb_axi_slave_mem;
    localparam int AW = 32, DW = 32, DEPTH = 1024, RD = 3;

    logic clk = 1'b0, reset = 1'b1;
    always #5 clk = ~clk;

    logic [AW-1:0] AWADDR = '0, ARADDR = '0;
    logic [7:0] AWLEN = '0, ARLEN = '0;
    logic [2:0] AWSIZE = '0, ARSIZE = '0;
    logic [1:0] AWBURST = '0, ARBURST = '0;
    logic AWVALID = 0, AWREADY, WLAST = 0, WVALID = 0, WREADY, BVALID, BREADY = 0;
    logic [DW-1:0] WDATA = '0, RDATA;
    logic [3:0] WSTRB = '0;
    logic [1:0] BRESP, RRESP;
    logic ARVALID = 0, ARREADY, RLAST, RVALID, RREADY = 0;

    axi_slave_mem #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH), .BASE_ADDR('0), .READY_DELAY(RD)) dut (
        .clk(clk), .reset(reset),
        .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY));

    int checks = 0, errors = 0;
    logic [31:0] wd [16];
    logic [3:0]  ws [16];
    logic        wl [16];
    logic [31:0] rd [16];
    logic [1:0]  rr [16];
    logic        rl [16];
    logic [1:0]  bresp_got;
    int aw_wait, ar_wait;
    logic first_rvalid;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [1:0]  exp_b;
        logic [31:0] exp_d;
        logic [1:0]  exp_r;
    } vec_t;
    vec_t tv [9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for handshake", nm);
    endtask

    task automatic do_aw(input logic [31:0] a, input logic [7:0] len, input logic [2:0] sz, input logic [1:0] bu);
        @(negedge clk);
        AWADDR = a; AWLEN = len; AWSIZE = sz; AWBURST = bu; AWVALID = 1;
        aw_wait = 0;
        #1;
        while (!AWREADY && aw_wait < 40) begin @(negedge clk); #1; aw_wait++; end
        if (!AWREADY) timeout("awready");
        @(negedge clk);
        AWVALID = 0;
    endtask

    task automatic write_burst(input logic [31:0] a, input logic [7:0] len, input logic [2:0] sz,
                               input logic [1:0] bu, input int bdelay, input logic [1:0] exp_b);
        int n;
        do_aw(a, len, sz, bu);
        for (int i = 0; i <= int'(len); i++) begin
            WDATA = wd[i]; WSTRB = ws[i]; WLAST = wl[i]; WVALID = 1;
            #1; n = 0;
            while (!WREADY && n < 40) begin @(negedge clk); #1; n++; end
            if (!WREADY) timeout("wready");
            @(negedge clk);
        end
        WVALID = 0; WLAST = 0;
        for (int i = 0; i < bdelay; i++) begin
            #1;
            chk("bvalid_hold", {31'd0, BVALID}, 32'd1);
            chk("bresp_hold", {30'd0, BRESP}, {30'd0, exp_b});
            @(negedge clk);
        end
        BREADY = 1;
        #1; n = 0;
        while (!BVALID && n < 40) begin @(negedge clk); #1; n++; end
        if (!BVALID) timeout("bvalid");
        bresp_got = BRESP;
        @(negedge clk);
        BREADY = 0;
    endtask

    task automatic read_burst(input logic [31:0] a, input logic [7:0] len, input logic [2:0] sz, input logic [1:0] bu);
        int n;
        @(negedge clk);
        ARADDR = a; ARLEN = len; ARSIZE = sz; ARBURST = bu; ARVALID = 1;
        ar_wait = 0;
        #1;
        while (!ARREADY && ar_wait < 40) begin @(negedge clk); #1; ar_wait++; end
        if (!ARREADY) timeout("arready");
        @(negedge clk);
        ARVALID = 0;
        #1;
        first_rvalid = RVALID;
        RREADY = 1;
        for (int i = 0; i <= int'(len); i++) begin
            n = 0;
            while (!RVALID && n < 40) begin @(negedge clk); #1; n++; end
            if (!RVALID) timeout("rvalid");
            rd[i] = RDATA; rr[i] = RRESP; rl[i] = RLAST;
            @(negedge clk); #1;
        end
        RREADY = 0;
    endtask

    initial begin
        tv[0] = '{32'h200, 32'h11223344, 4'hF, 3'd2, 2'b01, 2'b00, 32'h11223344, 2'b00};
        tv[1] = '{32'h202, 32'h00EE0000, 4'h4, 3'd0, 2'b01, 2'b00, 32'h11EE3344, 2'b00};
        tv[2] = '{32'h204, 32'hAABBCCDD, 4'hF, 3'd2, 2'b01, 2'b00, 32'hAABBCCDD, 2'b00};
        tv[3] = '{32'h204, 32'h55667788, 4'h5, 3'd2, 2'b01, 2'b00, 32'hAA66CC88, 2'b00};
        tv[4] = '{32'h1000, 32'h12345678, 4'hF, 3'd2, 2'b01, 2'b11, 32'h0, 2'b11};
        tv[5] = '{32'h20C, 32'h0BADF00D, 4'hF, 3'd2, 2'b11, 2'b10, 32'h0, 2'b10};
        tv[6] = '{32'h210, 32'h00000009, 4'hF, 3'd3, 2'b01, 2'b10, 32'h0, 2'b10};
        tv[7] = '{32'hFFC, 32'hCAFEF00D, 4'hF, 3'd2, 2'b00, 2'b00, 32'hCAFEF00D, 2'b00};
        tv[8] = '{32'h1008, 32'h77777777, 4'hF, 3'd3, 2'b01, 2'b11, 32'h0, 2'b11};

        // reset values
        repeat (2) @(negedge clk);
        chk("rst_awready", {31'd0, AWREADY}, 32'd0);
        chk("rst_wready", {31'd0, WREADY}, 32'd0);
        chk("rst_bvalid", {31'd0, BVALID}, 32'd0);
        chk("rst_arready", {31'd0, ARREADY}, 32'd0);
        chk("rst_rvalid", {31'd0, RVALID}, 32'd0);
        chk("rst_rlast", {31'd0, RLAST}, 32'd0);
        chk("rst_resp", {28'd0, BRESP, RRESP}, 32'd0);
        chk("rst_rdata", RDATA, 32'd0);
        reset = 0;

        // INCR 8-beat write then read back
        for (int i = 0; i < 8; i++) begin wd[i] = 32'h200 + i; ws[i] = 4'hF; wl[i] = (i == 7); end
        write_burst(32'h100, 8'd7, 3'd2, 2'b01, 0, 2'b00);
        chk("aw_delay", aw_wait, RD);
        chk("incr_bresp", {30'd0, bresp_got}, 32'd0);
        read_burst(32'h100, 8'd7, 3'd2, 2'b01);
        chk("ar_delay", ar_wait, RD);
        chk("first_rvalid", {31'd0, first_rvalid}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("incr_rdata%0d", i), rd[i], 32'h200 + i);
            chk($sformatf("incr_rlast%0d", i), {31'd0, rl[i]}, {31'd0, i == 7});
            chk($sformatf("incr_rresp%0d", i), {30'd0, rr[i]}, 32'd0);
        end

        // single-beat vector table
        for (int v = 0; v < 9; v++) begin
            wd[0] = tv[v].data; ws[0] = tv[v].strb; wl[0] = 1'b1;
            write_burst(tv[v].addr, 8'd0, tv[v].size, tv[v].burst, 0, 2'b00);
            chk($sformatf("tv%0d_bresp", v), {30'd0, bresp_got}, {30'd0, tv[v].exp_b});
            read_burst(tv[v].addr, 8'd0, tv[v].size, tv[v].burst);
            chk($sformatf("tv%0d_rdata", v), rd[0], tv[v].exp_d);
            chk($sformatf("tv%0d_rresp", v), {30'd0, rr[0]}, {30'd0, tv[v].exp_r});
            chk($sformatf("tv%0d_rlast", v), {31'd0, rl[0]}, 32'd1);
        end

        // WRAP write at 0x38: beats land at 0x38,0x3C,0x30,0x34
        for (int i = 0; i < 4; i++) begin wd[i] = 32'hB0 + i; ws[i] = 4'hF; wl[i] = (i == 3); end
        write_burst(32'h38, 8'd3, 3'd2, 2'b10, 0, 2'b00);
        chk("wrap_bresp", {30'd0, bresp_got}, 32'd0);
        read_burst(32'h30, 8'd3, 3'd2, 2'b01);
        chk("wrap_rd0", rd[0], 32'hB2);
        chk("wrap_rd1", rd[1], 32'hB3);
        chk("wrap_rd2", rd[2], 32'hB0);
        chk("wrap_rd3", rd[3], 32'hB1);

        // FIXED write: only the first beat touches the upper half
        wd[0] = 32'hAAAA1111; wd[1] = 32'hBBBB2222; wd[2] = 32'hCCCC3333; wd[3] = 32'hDDDD4444;
        ws[0] = 4'hF; ws[1] = 4'h3; ws[2] = 4'h3; ws[3] = 4'h3;
        for (int i = 0; i < 4; i++) wl[i] = (i == 3);
        write_burst(32'h40, 8'd3, 3'd2, 2'b00, 0, 2'b00);
        chk("fixed_bresp", {30'd0, bresp_got}, 32'd0);
        read_burst(32'h40, 8'd0, 3'd2, 2'b01);
        chk("fixed_rdata", rd[0], 32'hAAAA4444);

        // early WLAST: all beats still taken, SLVERR
        for (int i = 0; i < 4; i++) begin wd[i] = 32'h300 + i; ws[i] = 4'hF; wl[i] = (i == 1); end
        write_burst(32'h300, 8'd3, 3'd2, 2'b01, 0, 2'b00);
        chk("wlast_bresp", {30'd0, bresp_got}, 32'd2);
        read_burst(32'h1000, 8'd3, 3'd2, 2'b01);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("dec_rresp%0d", i), {30'd0, rr[i]}, 32'd3);
            chk($sformatf("dec_rdata%0d", i), rd[i], 32'd0);
            chk($sformatf("dec_rlast%0d", i), {31'd0, rl[i]}, {31'd0, i == 3});
        end

        // BREADY held low for 5 cycles on a DECERR response
        wd[0] = 32'h1; ws[0] = 4'hF; wl[0] = 1'b1;
        write_burst(32'h1000, 8'd0, 3'd2, 2'b01, 5, 2'b11);
        chk("hold_bresp", {30'd0, bresp_got}, 32'd3);

        // async reset during beat 2 of an 8-beat read
        @(negedge clk);
        ARADDR = 32'h100; ARLEN = 8'd7; ARSIZE = 3'd2; ARBURST = 2'b01; ARVALID = 1;
        ar_wait = 0;
        #1;
        while (!ARREADY && ar_wait < 40) begin @(negedge clk); #1; ar_wait++; end
        if (!ARREADY) timeout("rst_arready");
        @(negedge clk);
        ARVALID = 0; RREADY = 1;
        @(negedge clk);
        @(negedge clk); #1;
        chk("pre_rst_rvalid", {31'd0, RVALID}, 32'd1);
        chk("pre_rst_rdata", RDATA, 32'h202);
        reset = 1;
        #1;
        chk("async_rst_rvalid", {31'd0, RVALID}, 32'd0);
        chk("async_rst_rdata", RDATA, 32'd0);
        RREADY = 0;
        @(negedge clk);
        reset = 0;
        read_burst(32'h104, 8'd1, 3'd2, 2'b01);
        chk("post_rst_rd0", rd[0], 32'h201);
        chk("post_rst_rd1", rd[1], 32'h202);
        chk("post_rst_rlast", {30'd0, rl[0], rl[1]}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
